i2c_cmd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one I2C master between NUM_REQ command sources, e.g. the boot-time register-map sequencer and runtime tuning logic. It latches the granted requester's {reg_addr, reg_data} word, issues a single execute pulse to the I2C master, and waits for completion. It then returns a per-requester done pulse with the error status. An optional watchdog aborts a transaction whose completion never arrives.

---
 rtl/i2c_cmd_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter
//   Round-robin arbiter and sequencer sharing one I2C master between NUM_REQ
//   command sources. The granted requester's {reg_addr, reg_data} word is
//   latched, a single execute pulse is issued to the master, and completion
//   is returned as a one-cycle done pulse (with error status) to that requester.
//
//   Optional feature macro: I2C_ARB_TIMEOUT_EN
//     defined   : watchdog aborts a WAIT lasting TIMEOUT_CYCLES cycles
//                 (o_err=1, sticky o_timeout=1)
//     undefined : WAIT lasts until i_i2c_done; o_timeout stays 0
//
// Ports
//   i_clk, i_rstn    clock, asynchronous active-low reset
//   i_req            per-requester request level, held until matching o_done
//   i_req_data       command words, requester n at [n*REG_WIDTH +: REG_WIDTH]
//   o_grant          one-hot grant, held for the whole transaction
//   o_done           one-cycle completion pulse to the granted requester
//   o_err            one-cycle error flag coincident with o_done
//   o_busy           high whenever the sequencer is not idle
//   o_i2c_exec       one-cycle start pulse to the I2C master
//   o_i2c_data       latched command word for the I2C master
//   i_i2c_done       one-cycle completion pulse from the I2C master
//   i_i2c_nack       ack-error flag, valid with i_i2c_done
//   o_timeout        sticky watchdog flag
module i2c_cmd_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int REG_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*REG_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [NUM_REQ-1:0]           o_done,
  output logic                         o_err,
  output logic                         o_busy,
  output logic                         o_i2c_exec,
  output logic [REG_WIDTH-1:0]         o_i2c_data,
  input  logic                         i_i2c_done,
  input  logic                         i_i2c_nack,
  output logic                         o_timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || REG_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("i2c_cmd_arbiter: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t               state, nxt_state;
  logic [PW-1:0]        rr_ptr, nxt_rr;
  logic [PW-1:0]        gidx, nxt_gidx;
  logic [NUM_REQ-1:0]   nxt_grant, nxt_done;
  logic                 nxt_err, nxt_busy, nxt_exec, nxt_timeout;
  logic [REG_WIDTH-1:0] nxt_data;
  logic                 finish;

  logic [PW-1:0]        win, idx;
  logic                 found;
  logic [REG_WIDTH-1:0] win_word;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt, nxt_wd_cnt;
`endif

  // Round-robin search: walk the requesters starting at rr_ptr, wrapping at
  // NUM_REQ (which need not be a power of two), first hit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    win_word = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win == PW'(k)) win_word = i_req_data[k*REG_WIDTH +: REG_WIDTH];
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    nxt_state   = state;
    nxt_rr      = rr_ptr;
    nxt_gidx    = gidx;
    nxt_grant   = o_grant;
    nxt_done    = '0;
    nxt_err     = 1'b0;
    nxt_exec    = 1'b0;
    nxt_data    = o_i2c_data;
    nxt_timeout = o_timeout;
    finish      = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    nxt_wd_cnt  = wd_cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          nxt_grant = NUM_REQ'(1) << win;
          nxt_gidx  = win;
          nxt_data  = win_word;
          nxt_state = ISSUE;
        end
      end
      ISSUE: begin
        nxt_exec  = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
        nxt_wd_cnt = '0;
`endif
        nxt_state = WAIT;
      end
      WAIT: begin
        // A completion landing on the watchdog limit takes the normal path.
        if (i_i2c_done) begin
          finish  = 1'b1;
          nxt_err = i_i2c_nack;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          finish      = 1'b1;
          nxt_err     = 1'b1;
          nxt_timeout = 1'b1;
        end else begin
          nxt_wd_cnt = wd_cnt + 1'b1;
        end
`endif
      end
      default: nxt_state = IDLE;
    endcase

    if (finish) begin
      nxt_done  = o_grant;
      nxt_grant = '0;
      nxt_rr    = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      nxt_state = IDLE;
    end

    nxt_busy = (nxt_state != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gidx       <= '0;
      o_grant    <= '0;
      o_done     <= '0;
      o_err      <= 1'b0;
      o_busy     <= 1'b0;
      o_i2c_exec <= 1'b0;
      o_i2c_data <= '0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= nxt_state;
      rr_ptr     <= nxt_rr;
      gidx       <= nxt_gidx;
      o_grant    <= nxt_grant;
      o_done     <= nxt_done;
      o_err      <= nxt_err;
      o_busy     <= nxt_busy;
      o_i2c_exec <= nxt_exec;
      o_i2c_data <= nxt_data;
      o_timeout  <= nxt_timeout;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) wd_cnt <= '0;
    else         wd_cnt <= nxt_wd_cnt;
  end
`endif

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Testbench for i2c_cmd_arbiter: randomized and directed transactions
// checked against a round-robin reference model kept in the bench.
module tb_i2c_cmd_arbiter;
  localparam int N  = 2;
  localparam int W  = 16;
  localparam int TO = 50;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant, done;
  logic           err, busy, exec, timeout;
  logic [W-1:0]   i2c_data;
  logic           i2c_done, nack;

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.NUM_REQ(N), .REG_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_req_data(req_data),
    .o_grant(grant), .o_done(done), .o_err(err), .o_busy(busy),
    .o_i2c_exec(exec), .o_i2c_data(i2c_data), .i_i2c_done(i2c_done),
    .i_i2c_nack(nack), .o_timeout(timeout)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int        rr_m = 0;
  logic      to_m = 1'b0;
  logic [W-1:0] words [N];

  // Observations captured by run_txn
  logic [N-1:0] ob_grant, ob_done_at_grant, ob_done, ob_grant_end;
  logic [W-1:0] ob_data, ob_data_end;
  logic         ob_busy, ob_err, ob_busy_end, ob_to;
  int           ob_exec, ob_early;

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_words;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
  endtask

  task automatic rand_words;
    for (int i = 0; i < N; i++) words[i] = W'($urandom);
    load_words();
  endtask

  // Drives one transaction from an idle DUT with i_req already applied.
  // lat = number of cycles sampled in WAIT before i_i2c_done is raised.
  task automatic run_txn(input int lat, input logic nk, input bit no_done,
                         input bit chg_data, input bit drop_req);
    tick();
    ob_grant = grant; ob_data = i2c_data; ob_busy = busy; ob_done_at_grant = done;
    ob_exec = 0; ob_early = 0;
    if (exec) ob_exec++;
    tick();
    for (int i = 0; i < lat; i++) begin
      if (exec) ob_exec++;
      if (done !== '0) ob_early++;
      if (i == 0 && chg_data) req_data = ~req_data;
      if (i == 0 && drop_req) req = '0;
      tick();
    end
    if (exec) ob_exec++;
    if (done !== '0) ob_early++;
    ob_data_end = i2c_data;
    if (!no_done) begin i2c_done = 1'b1; nack = nk; end
    tick();
    i2c_done = 1'b0; nack = 1'b0;
    ob_done = done; ob_err = err; ob_grant_end = grant; ob_busy_end = busy; ob_to = timeout;
  endtask

  task automatic test_reset;
    rstn = 1'b0; req = 2'b11; i2c_done = 1'b0; nack = 1'b0;
    rand_words();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (grant !== '0)    begin errors++; $display("FAIL reset_grant: got %b want 0", grant); end
    checks++; if (done !== '0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (exec !== 1'b0)   begin errors++; $display("FAIL reset_exec: got %b want 0", exec); end
    checks++; if (i2c_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", i2c_data); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rstn = 1'b1;
    rr_m = 0; to_m = 1'b0;
  endtask

  task automatic test_simultaneous;
    int w;
    logic [N-1:0] eg;
    int order [4] = '{0, 1, 0, 1};
    for (int t = 0; t < 4; t++) begin
      w = rr_pick(req, rr_m);
      eg = N'(1) << w;
      run_txn($urandom_range(2, 6), 1'b0, 0, 0, 0);
      checks++; if (w != order[t]) begin errors++; $display("FAIL simul_model_order[%0d]: got %0d want %0d", t, w, order[t]); end
      checks++; if (ob_grant !== eg) begin errors++; $display("FAIL simul_grant[%0d]: got %b want %b", t, ob_grant, eg); end
      checks++; if (ob_data !== words[w]) begin errors++; $display("FAIL simul_data[%0d]: got %h want %h", t, ob_data, words[w]); end
      checks++; if (ob_exec != 1) begin errors++; $display("FAIL simul_exec_count[%0d]: got %0d want 1", t, ob_exec); end
      checks++; if (ob_done !== eg) begin errors++; $display("FAIL simul_done[%0d]: got %b want %b", t, ob_done, eg); end
      checks++; if (ob_done_at_grant !== '0) begin errors++; $display("FAIL simul_done_width[%0d]: got %b want 0", t, ob_done_at_grant); end
      rr_m = (w + 1) % N;
      rand_words();
    end
  endtask

  task automatic test_single;
    req = 2'b01;
    words[0] = 16'h1280; words[1] = W'($urandom);
    load_words();
    run_txn(20, 1'b0, 0, 0, 0);
    checks++; if (ob_grant !== 2'b01)    begin errors++; $display("FAIL single_grant: got %b want 01", ob_grant); end
    checks++; if (ob_data !== 16'h1280)  begin errors++; $display("FAIL single_data: got %h want 1280", ob_data); end
    checks++; if (ob_busy !== 1'b1)      begin errors++; $display("FAIL single_busy: got %b want 1", ob_busy); end
    checks++; if (ob_exec != 1)          begin errors++; $display("FAIL single_exec_count: got %0d want 1", ob_exec); end
    checks++; if (ob_early != 0)         begin errors++; $display("FAIL single_early_done: got %0d want 0", ob_early); end
    checks++; if (ob_done !== 2'b01)     begin errors++; $display("FAIL single_done: got %b want 01", ob_done); end
    checks++; if (ob_err !== 1'b0)       begin errors++; $display("FAIL single_err: got %b want 0", ob_err); end
    checks++; if (ob_grant_end !== '0)   begin errors++; $display("FAIL single_grant_clear: got %b want 0", ob_grant_end); end
    checks++; if (ob_busy_end !== 1'b0)  begin errors++; $display("FAIL single_busy_end: got %b want 0", ob_busy_end); end
    rr_m = 1;
    req = '0;
    tick();
    checks++; if (done !== '0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_nack;
    req = 2'b10; rand_words();
    run_txn(5, 1'b1, 0, 0, 0);
    checks++; if (ob_done !== 2'b10) begin errors++; $display("FAIL nack_done: got %b want 10", ob_done); end
    checks++; if (ob_err !== 1'b1)   begin errors++; $display("FAIL nack_err: got %b want 1", ob_err); end
    rr_m = 0;
    req = 2'b01; rand_words();
    run_txn(3, 1'b0, 0, 0, 0);
    checks++; if (ob_grant !== 2'b01)  begin errors++; $display("FAIL nack_next_grant: got %b want 01", ob_grant); end
    checks++; if (ob_done !== 2'b01)   begin errors++; $display("FAIL nack_next_done: got %b want 01", ob_done); end
    checks++; if (ob_err !== 1'b0)     begin errors++; $display("FAIL nack_next_err: got %b want 0", ob_err); end
    rr_m = 1;
  endtask

  task automatic test_spurious;
    int w;
    req = '0;
    i2c_done = 1'b1; nack = 1'b1;
    tick();
    i2c_done = 1'b0; nack = 1'b0;
    checks++; if (done !== '0)   begin errors++; $display("FAIL idle_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL idle_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    tick();
    checks++; if (done !== '0)   begin errors++; $display("FAIL idle_done_late: got %b want 0", done); end
    req = 2'b11; rand_words();
    w = rr_pick(req, rr_m);
    run_txn(8, 1'b0, 0, 1, 1);
    checks++; if (ob_data_end !== words[w]) begin errors++; $display("FAIL late_data_hold: got %h want %h", ob_data_end, words[w]); end
    checks++; if (ob_done !== (N'(1) << w)) begin errors++; $display("FAIL drop_req_done: got %b want %b", ob_done, N'(1) << w); end
    rr_m = (w + 1) % N;
  endtask

  task automatic test_random;
    int w, lat;
    logic nk;
    bit chg, drp;
    logic [N-1:0] eg;
    for (int t = 0; t < 24; t++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      rand_words();
      lat = $urandom_range(1, 10);
      nk  = 1'($urandom);
      chg = 1'($urandom);
      drp = 1'($urandom);
      w = rr_pick(req, rr_m);
      eg = N'(1) << w;
      run_txn(lat, nk, 0, chg, drp);
      checks++; if (ob_grant !== eg) begin errors++; $display("FAIL rnd_grant[%0d]: got %b want %b", t, ob_grant, eg); end
      checks++; if (ob_data_end !== words[w]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", t, ob_data_end, words[w]); end
      checks++; if (ob_exec != 1 || ob_early != 0) begin errors++; $display("FAIL rnd_exec_early[%0d]: got exec=%0d early=%0d want 1/0", t, ob_exec, ob_early); end
      checks++; if (ob_done !== eg || ob_err !== nk) begin errors++; $display("FAIL rnd_done_err[%0d]: got %b/%b want %b/%b", t, ob_done, ob_err, eg, nk); end
      checks++; if (ob_to !== to_m) begin errors++; $display("FAIL rnd_timeout[%0d]: got %b want %b", t, ob_to, to_m); end
      rr_m = (w + 1) % N;
    end
  endtask

  task automatic test_watchdog;
    logic nk;
    int w;
    req = 2'b01; rand_words(); nk = 1'($urandom);
    w = rr_pick(req, rr_m);
    run_txn(TO - 1, nk, 0, 0, 0);
    checks++; if (ob_done !== 2'b01 || ob_err !== nk) begin errors++; $display("FAIL wd_limit_done: got %b/%b want 01/%b", ob_done, ob_err, nk); end
    checks++; if (ob_to !== to_m) begin errors++; $display("FAIL wd_limit_timeout: got %b want %b", ob_to, to_m); end
    rr_m = (w + 1) % N;
`ifdef I2C_ARB_TIMEOUT_EN
    req = 2'b10; rand_words();
    run_txn(TO - 1, 1'b0, 1, 0, 0);
    to_m = 1'b1;
    checks++; if (ob_early != 0) begin errors++; $display("FAIL wd_early: got %0d want 0", ob_early); end
    checks++; if (ob_done !== 2'b10 || ob_err !== 1'b1) begin errors++; $display("FAIL wd_abort: got %b/%b want 10/1", ob_done, ob_err); end
    checks++; if (ob_to !== 1'b1) begin errors++; $display("FAIL wd_timeout_set: got %b want 1", ob_to); end
    rr_m = 0;
    req = 2'b01; rand_words();
    run_txn(4, 1'b0, 0, 0, 0);
    checks++; if (ob_to !== 1'b1 || ob_err !== 1'b0) begin errors++; $display("FAIL wd_sticky: got to=%b err=%b want 1/0", ob_to, ob_err); end
    rr_m = 1;
`endif
  endtask

  task automatic test_reset_mid;
    if (rr_m == 0) begin
      req = 2'b01; rand_words();
      run_txn(2, 1'b0, 0, 0, 0);
      checks++; if (ob_done !== 2'b01) begin errors++; $display("FAIL rmid_pre_done: got %b want 01", ob_done); end
      rr_m = 1;
    end
    req = 2'b11; rand_words();
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rmid_grant_before: got %b want 10", grant); end
    repeat (3) tick();
    #3 rstn = 1'b0;
    #1;
    checks++; if ({grant, done, err, busy, exec, timeout} !== '0 || i2c_data !== '0)
      begin errors++; $display("FAIL rmid_async_clear: got g=%b d=%b e=%b b=%b x=%b t=%b data=%h want all 0", grant, done, err, busy, exec, timeout, i2c_data); end
    @(posedge clk); #1;
    checks++; if (done !== '0 || grant !== '0) begin errors++; $display("FAIL rmid_hold: got d=%b g=%b want 0", done, grant); end
    rstn = 1'b1;
    rr_m = 0; to_m = 1'b0;
    run_txn(3, 1'b0, 0, 0, 0);
    checks++; if (ob_grant !== 2'b01) begin errors++; $display("FAIL rmid_regrant: got %b want 01", ob_grant); end
    checks++; if (ob_done !== 2'b01 || ob_to !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b/%b want 01/0", ob_done, ob_to); end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_nack();
    test_spurious();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
